// File: rtl/dmni_br_rx_queue.sv
// BrLite broadcast receive queue: splits incoming entries by ksvc class into a
// lossless service FIFO (backpressured) and a lossy monitor FIFO with a drop counter.
module dmni_br_rx_queue #(
  parameter int unsigned           PAYLOAD_SIZE  = 16,
  parameter int unsigned           SEQ_SIZE      = 16,
  parameter int unsigned           KSVC_SIZE     = 4,
  parameter int unsigned           SVC_DEPTH     = 8,
  parameter int unsigned           MON_DEPTH     = 16,
  parameter logic [KSVC_SIZE-1:0]  MON_KSVC_MIN  = 'h8,
  parameter int unsigned           MON_THRESHOLD = 8,
  parameter int unsigned           DROP_CNT_SIZE = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             rx_valid_i,
  output logic                             rx_ready_o,
  input  logic [PAYLOAD_SIZE-1:0]          rx_payload_i,
  input  logic [SEQ_SIZE-1:0]              rx_seq_source_i,
  input  logic [KSVC_SIZE-1:0]             rx_ksvc_i,
  output logic                             svc_empty_o,
  output logic [PAYLOAD_SIZE-1:0]          svc_payload_o,
  output logic [SEQ_SIZE-1:0]              svc_seq_source_o,
  output logic [KSVC_SIZE-1:0]             svc_ksvc_o,
  input  logic                             svc_pop_i,
  output logic [$clog2(SVC_DEPTH+1)-1:0]   svc_cnt_o,
  output logic                             mon_empty_o,
  output logic [PAYLOAD_SIZE-1:0]          mon_payload_o,
  output logic [SEQ_SIZE-1:0]              mon_seq_source_o,
  output logic [KSVC_SIZE-1:0]             mon_ksvc_o,
  input  logic                             mon_pop_i,
  output logic [$clog2(MON_DEPTH+1)-1:0]   mon_cnt_o,
  output logic [DROP_CNT_SIZE-1:0]         mon_drop_cnt_o,
  input  logic                             drop_clr_i,
  output logic                             irq_svc_o,
  output logic                             irq_mon_o
);

  localparam int unsigned ENTRY_W = PAYLOAD_SIZE + SEQ_SIZE + KSVC_SIZE;
  localparam int unsigned SVC_AW  = $clog2(SVC_DEPTH);
  localparam int unsigned SVC_CW  = $clog2(SVC_DEPTH + 1);
  localparam int unsigned MON_AW  = $clog2(MON_DEPTH);
  localparam int unsigned MON_CW  = $clog2(MON_DEPTH + 1);
  localparam logic [SVC_CW-1:0] SVC_FULL_CNT = SVC_CW'(SVC_DEPTH);
  localparam logic [MON_CW-1:0] MON_FULL_CNT = MON_CW'(MON_DEPTH);
  localparam logic [MON_CW-1:0] MON_IRQ_CNT  = MON_CW'(MON_THRESHOLD);

  logic [ENTRY_W-1:0] rx_entry;
  logic               is_mon;

  logic [ENTRY_W-1:0] svc_mem [SVC_DEPTH];
  logic [SVC_AW-1:0]  svc_wr, svc_rd;
  logic [SVC_CW-1:0]  svc_cnt;
  logic               svc_full, svc_empty, svc_push, svc_pop;
  logic [ENTRY_W-1:0] svc_head;

  logic [ENTRY_W-1:0] mon_mem [MON_DEPTH];
  logic [MON_AW-1:0]  mon_wr, mon_rd;
  logic [MON_CW-1:0]  mon_cnt;
  logic               mon_full, mon_empty, mon_in, mon_push, mon_pop, mon_drop;
  logic [ENTRY_W-1:0] mon_head;

  logic [DROP_CNT_SIZE-1:0] drop_cnt;

  assign rx_entry = {rx_payload_i, rx_seq_source_i, rx_ksvc_i};
  assign is_mon   = (rx_ksvc_i >= MON_KSVC_MIN);

  assign svc_full  = (svc_cnt == SVC_FULL_CNT);
  assign svc_empty = (svc_cnt == '0);
  assign svc_push  = rx_valid_i && !is_mon && !svc_full;
  assign svc_pop   = svc_pop_i && !svc_empty;

  // A full monitor FIFO still takes the new entry when the head leaves in the same cycle.
  assign mon_full  = (mon_cnt == MON_FULL_CNT);
  assign mon_empty = (mon_cnt == '0);
  assign mon_in    = rx_valid_i && is_mon;
  assign mon_pop   = mon_pop_i && !mon_empty;
  assign mon_push  = mon_in && (!mon_full || mon_pop);
  assign mon_drop  = mon_in && mon_full && !mon_pop;

  assign rx_ready_o = is_mon || !svc_full;

  always_ff @(posedge clk_i) begin
    if (rst_ni && svc_push) svc_mem[svc_wr] <= rx_entry;
    if (rst_ni && mon_push) mon_mem[mon_wr] <= rx_entry;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      svc_wr  <= '0;
      svc_rd  <= '0;
      svc_cnt <= '0;
    end else begin
      if (svc_push) svc_wr <= svc_wr + SVC_AW'(1);
      if (svc_pop)  svc_rd <= svc_rd + SVC_AW'(1);
      if (svc_push && !svc_pop)      svc_cnt <= svc_cnt + SVC_CW'(1);
      else if (!svc_push && svc_pop) svc_cnt <= svc_cnt - SVC_CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mon_wr  <= '0;
      mon_rd  <= '0;
      mon_cnt <= '0;
    end else begin
      if (mon_push) mon_wr <= mon_wr + MON_AW'(1);
      if (mon_pop)  mon_rd <= mon_rd + MON_AW'(1);
      if (mon_push && !mon_pop)      mon_cnt <= mon_cnt + MON_CW'(1);
      else if (!mon_push && mon_pop) mon_cnt <= mon_cnt - MON_CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drop_cnt <= '0;
    end else if (drop_clr_i) begin
      drop_cnt <= mon_drop ? DROP_CNT_SIZE'(1) : '0;
    end else if (mon_drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CNT_SIZE'(1);
    end
  end

  assign svc_head = svc_empty ? '0 : svc_mem[svc_rd];
  assign mon_head = mon_empty ? '0 : mon_mem[mon_rd];

  assign svc_payload_o    = svc_head[ENTRY_W-1 -: PAYLOAD_SIZE];
  assign svc_seq_source_o = svc_head[KSVC_SIZE +: SEQ_SIZE];
  assign svc_ksvc_o       = svc_head[0 +: KSVC_SIZE];
  assign svc_cnt_o        = svc_cnt;
  assign svc_empty_o      = svc_empty;

  assign mon_payload_o    = mon_head[ENTRY_W-1 -: PAYLOAD_SIZE];
  assign mon_seq_source_o = mon_head[KSVC_SIZE +: SEQ_SIZE];
  assign mon_ksvc_o       = mon_head[0 +: KSVC_SIZE];
  assign mon_cnt_o        = mon_cnt;
  assign mon_empty_o      = mon_empty;

  assign mon_drop_cnt_o = drop_cnt;
  assign irq_svc_o      = !svc_empty;
  assign irq_mon_o      = (mon_cnt >= MON_IRQ_CNT);

endmodule

// File: tb/tb_dmni_br_rx_queue.sv
// Bench for dmni_br_rx_queue: directed scenarios plus random traffic, checked
// against a queue-based reference model; a second instance has a 2-bit drop counter.
module tb_dmni_br_rx_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [15:0] rx_payload;
  logic [15:0] rx_seq;
  logic [3:0]  rx_ksvc;
  logic        svc_pop, mon_pop, drop_clr;

  logic        rdy, svc_empty, mon_empty, irq_svc, irq_mon;
  logic [15:0] svc_payload, svc_seq, mon_payload, mon_seq, drop_cnt;
  logic [3:0]  svc_ksvc, mon_ksvc;
  logic [3:0]  svc_cnt;
  logic [4:0]  mon_cnt;

  logic        d2_rdy, d2_svc_empty, d2_mon_empty, d2_irq_svc, d2_irq_mon;
  logic [15:0] d2_svc_payload, d2_svc_seq, d2_mon_payload, d2_mon_seq;
  logic [3:0]  d2_svc_ksvc, d2_mon_ksvc;
  logic [3:0]  d2_svc_cnt;
  logic [4:0]  d2_mon_cnt;
  logic [1:0]  d2_drop_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [35:0] svcq[$];
  logic [35:0] monq[$];
  int unsigned drops = 0;
  bit          known = 0;

  always #5 clk = ~clk;

  dmni_br_rx_queue dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_valid_i(rx_valid), .rx_ready_o(rdy),
    .rx_payload_i(rx_payload), .rx_seq_source_i(rx_seq), .rx_ksvc_i(rx_ksvc),
    .svc_empty_o(svc_empty), .svc_payload_o(svc_payload), .svc_seq_source_o(svc_seq),
    .svc_ksvc_o(svc_ksvc), .svc_pop_i(svc_pop), .svc_cnt_o(svc_cnt),
    .mon_empty_o(mon_empty), .mon_payload_o(mon_payload), .mon_seq_source_o(mon_seq),
    .mon_ksvc_o(mon_ksvc), .mon_pop_i(mon_pop), .mon_cnt_o(mon_cnt),
    .mon_drop_cnt_o(drop_cnt), .drop_clr_i(drop_clr),
    .irq_svc_o(irq_svc), .irq_mon_o(irq_mon)
  );

  dmni_br_rx_queue #(.DROP_CNT_SIZE(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .rx_valid_i(rx_valid), .rx_ready_o(d2_rdy),
    .rx_payload_i(rx_payload), .rx_seq_source_i(rx_seq), .rx_ksvc_i(rx_ksvc),
    .svc_empty_o(d2_svc_empty), .svc_payload_o(d2_svc_payload), .svc_seq_source_o(d2_svc_seq),
    .svc_ksvc_o(d2_svc_ksvc), .svc_pop_i(svc_pop), .svc_cnt_o(d2_svc_cnt),
    .mon_empty_o(d2_mon_empty), .mon_payload_o(d2_mon_payload), .mon_seq_source_o(d2_mon_seq),
    .mon_ksvc_o(d2_mon_ksvc), .mon_pop_i(mon_pop), .mon_cnt_o(d2_mon_cnt),
    .mon_drop_cnt_o(d2_drop_cnt), .drop_clr_i(drop_clr),
    .irq_svc_o(d2_irq_svc), .irq_mon_o(d2_irq_mon)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [35:0] es, em;
    int unsigned sat16, sat2;
    es    = (svcq.size() != 0) ? svcq[0] : 36'd0;
    em    = (monq.size() != 0) ? monq[0] : 36'd0;
    sat16 = (drops > 65535) ? 65535 : drops;
    sat2  = (drops > 3) ? 3 : drops;
    check("svc_empty", svc_empty, svcq.size() == 0);
    check("svc_cnt",   svc_cnt,   svcq.size());
    check("svc_head",  {svc_payload, svc_seq, svc_ksvc}, es);
    check("mon_empty", mon_empty, monq.size() == 0);
    check("mon_cnt",   mon_cnt,   monq.size());
    check("mon_head",  {mon_payload, mon_seq, mon_ksvc}, em);
    check("irq_svc",   irq_svc,   svcq.size() != 0);
    check("irq_mon",   irq_mon,   monq.size() >= 8);
    check("drop_cnt",  drop_cnt,  sat16);
    check("d2_drop_cnt", d2_drop_cnt, sat2);
    check("d2_state", {d2_svc_empty, d2_svc_cnt, d2_mon_empty, d2_mon_cnt, d2_irq_svc, d2_irq_mon},
          {svc_empty, svc_cnt, mon_empty, mon_cnt, irq_svc, irq_mon});
    check("d2_heads", {d2_svc_payload, d2_svc_seq, d2_svc_ksvc, d2_mon_payload, d2_mon_seq, d2_mon_ksvc},
          {es, em});
  endtask

  task automatic step(input logic v, input logic [3:0] k, input logic [15:0] p,
                      input logic sp, input logic mp, input logic clr, input logic rn);
    bit mon_cls, s_pop, m_pop, dropped;
    logic [35:0] e;
    @(negedge clk);
    rx_valid = v; rx_ksvc = k; rx_payload = p; rx_seq = 16'($urandom);
    svc_pop = sp; mon_pop = mp; drop_clr = clr; rst_n = rn;
    #1;
    mon_cls = (k >= 4'd8);
    if (known) begin
      check("rx_ready",    rdy,    mon_cls || (svcq.size() != 8));
      check("d2_rx_ready", d2_rdy, mon_cls || (svcq.size() != 8));
    end
    e = {p, rx_seq, k};
    @(posedge clk);
    if (!rn) begin
      svcq.delete(); monq.delete(); drops = 0; known = 1;
    end else begin
      s_pop = sp && svcq.size() != 0;
      if (v && !mon_cls && svcq.size() != 8) begin
        if (s_pop) void'(svcq.pop_front());
        svcq.push_back(e);
      end else if (s_pop) void'(svcq.pop_front());
      m_pop   = mp && monq.size() != 0;
      dropped = v && mon_cls && monq.size() == 16 && !m_pop;
      if (m_pop) void'(monq.pop_front());
      if (v && mon_cls && !dropped) monq.push_back(e);
      if (clr) drops = dropped ? 1 : 0;
      else if (dropped) drops++;
    end
    #1;
    if (known) check_outputs();
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_ksvc = '0; rx_payload = '0; rx_seq = '0;
    svc_pop = 1'b0; mon_pop = 1'b0; drop_clr = 1'b0;

    // reset with valid asserted
    step(1, 4'd2, 16'h1234, 0, 0, 0, 0);
    step(1, 4'd2, 16'h1234, 0, 0, 0, 0);

    // service ordering and full stall
    for (int i = 1; i <= 8; i++) step(1, 4'd2, 16'(i), 0, 0, 0, 1);
    check("svc_full_cnt", svc_cnt, 4'd8);
    step(0, 4'd9, 16'h0, 0, 0, 0, 1);
    step(1, 4'd2, 16'h0009, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 4'd2, 16'h0, 1, 0, 0, 1);

    // monitor overflow, then full + pop + push
    for (int i = 1; i <= 20; i++) step(1, 4'd9, 16'(16'h0100 + i), 0, 0, 0, 1);
    check("mon_over_cnt", mon_cnt, 5'd16);
    check("mon_over_drop", drop_cnt, 16'd4);
    check("mon_over_head", mon_payload, 16'h0101);
    step(1, 4'd9, 16'hBEEF, 0, 1, 0, 1);
    check("mon_swap_drop", drop_cnt, 16'd4);
    for (int i = 0; i < 17; i++) step(0, 4'd0, 16'h0, 0, 1, 0, 1);

    // drop clear interplay and 2-bit saturation
    for (int i = 1; i <= 16; i++) step(1, 4'd12, 16'(16'h0200 + i), 0, 0, 0, 1);
    for (int i = 0; i < 2; i++)  step(1, 4'd15, 16'hDEAD, 0, 0, 0, 1);
    step(1, 4'd8, 16'hD00D, 0, 0, 1, 1);
    check("clr_with_drop", drop_cnt, 16'd1);
    step(0, 4'd8, 16'h0, 0, 0, 1, 1);
    check("clr_alone", drop_cnt, 16'd0);
    for (int i = 0; i < 5; i++) step(1, 4'd10, 16'hF00D, 0, 0, 0, 1);
    check("sat2", d2_drop_cnt, 2'd3);

    // reset while both FIFOs are half full
    for (int i = 0; i < 8; i++) step(0, 4'd0, 16'h0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 4'd3, 16'(16'h0300 + i), 0, 0, 0, 1);
    step(1, 4'd3, 16'h0399, 0, 0, 0, 0);
    check("rst_mid_empty", {svc_empty, mon_empty, irq_svc, irq_mon}, 4'b1100);

    // random traffic with shifting pop pressure
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 600; i++) begin
        int unsigned pp;
        pp = (ph == 0) ? 10 : (ph == 1) ? 50 : 90;
        step($urandom_range(0, 99) < 75, 4'($urandom_range(0, 15)), 16'($urandom),
             $urandom_range(0, 99) < pp, $urandom_range(0, 99) < pp,
             $urandom_range(0, 31) == 0, $urandom_range(0, 255) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
